// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB data-phase return mux with a built-in two-cycle ERROR default slave
module ahb_resp_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL_SRAM,
  input  logic                  HSEL_SPLIT,
  input  logic                  HSEL_DEFAULT,
  input  logic [DATA_WIDTH-1:0] HRDATA_SRAM,
  input  logic                  HREADYOUT_SRAM,
  input  logic [RESP_WIDTH-1:0] HRESP_SRAM,
  input  logic [DATA_WIDTH-1:0] HRDATA_SPLIT,
  input  logic                  HREADYOUT_SPLIT,
  input  logic [RESP_WIDTH-1:0] HRESP_SPLIT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic [RESP_WIDTH-1:0] HRESP,
  output logic [1:0]            dphase_id
);
  localparam logic [1:0] ID_NONE = 2'd0, SRAM_SLAVE = 2'd1, SPLIT_SLAVE = 2'd2, DEFAULT_SLAVE = 2'd3;
  localparam logic [RESP_WIDTH-1:0] OKAY = '0, ERROR = RESP_WIDTH'(1);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;
  ds_t state, state_nxt;
  logic [1:0] sel_id;
  logic cap_default, ds_ready;
  logic [RESP_WIDTH-1:0] ds_resp;
  // priority-encode the address-phase selects (SRAM > SPLIT > DEFAULT)
  always_comb sel_id = HSEL_SRAM ? SRAM_SLAVE : HSEL_SPLIT ? SPLIT_SLAVE : HSEL_DEFAULT ? DEFAULT_SLAVE : ID_NONE;
  assign cap_default = HREADY && sel_id == DEFAULT_SLAVE;
  // data-phase owner advances only when the current transfer completes
  always_ff @(posedge HCLK)
    if (HRESET) dphase_id <= ID_NONE;
    else if (HREADY) dphase_id <= sel_id;
  // default-slave state register
  always_ff @(posedge HCLK) state <= HRESET ? DS_IDLE : state_nxt;
  // default-slave next state: ERR1 always continues to ERR2, a new capture restarts the pair
  always_comb state_nxt = state == DS_ERR1 ? DS_ERR2 : cap_default ? DS_ERR1 : DS_IDLE;
  // default-slave outputs: wait+ERROR, then ready+ERROR
  always_comb begin
    ds_ready = state != DS_ERR1;
    ds_resp  = state == DS_IDLE ? OKAY : ERROR;
  end
  // return-path mux driven by the registered data-phase owner
  always_comb begin
    HRDATA = dphase_id == SRAM_SLAVE ? HRDATA_SRAM : dphase_id == SPLIT_SLAVE ? HRDATA_SPLIT : '0;
    HREADY = dphase_id == SRAM_SLAVE ? HREADYOUT_SRAM : dphase_id == SPLIT_SLAVE ? HREADYOUT_SPLIT :
             dphase_id == DEFAULT_SLAVE ? ds_ready : 1'b1;
    HRESP  = dphase_id == SRAM_SLAVE ? HRESP_SRAM : dphase_id == SPLIT_SLAVE ? HRESP_SPLIT :
             dphase_id == DEFAULT_SLAVE ? ds_resp : OKAY;
  end
  // more than one select high at once is a decoder protocol error
  always_ff @(posedge HCLK)
    if (!HRESET) assert ($onehot0({HSEL_SRAM, HSEL_SPLIT, HSEL_DEFAULT})) else $error("multiple HSEL_* asserted");
endmodule
